ds18b20_sequencer: RTL and testbench

Measurement sequencer sitting directly upstream of the `ds18b20` command controller. It issues the fixed command sequence for one temperature reading (reset/detect, convert, poll for completion, reset/detect, read scratchpad, fetch temperature) via the controller's `i_command`/`i_enable`/`o_irq` handshake. It captures the 16-bit signed result and publishes it as raw and integer/fraction temperature with a one-cycle valid strobe. Supports one-shot and free-running periodic operation.

---
 rtl/ds18b20_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ds18b20_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ds18b20_sequencer.sv
// rtl/ds18b20_sequencer.sv - one-shot/periodic DS18B20 temperature measurement sequencer
// Walks the fixed controller command list and publishes a range-checked temperature.
module ds18b20_sequencer #(
  parameter int P_PERIOD  = 48_000_000,
  parameter int P_TIMEOUT = 48_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_auto,
  output logic [5:0]  o_command,
  output logic        o_enable,
  input  logic        i_busy,
  input  logic        i_irq,
  input  logic        i_detect,
  input  logic [15:0] i_data,
  output logic [15:0] o_temp,
  output logic [7:0]  o_temp_int,
  output logic [3:0]  o_temp_frac,
  output logic        o_valid,
  output logic        o_busy,
  output logic [2:0]  o_err
);

  localparam int CNT_MAX = (P_PERIOD > P_TIMEOUT) ? P_PERIOD : P_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(P_TIMEOUT - 1);
  localparam logic [CW-1:0] PERIOD_LAST  = CW'(P_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_PUBLISH, S_PERIOD
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    command_q, command_d;
  logic [15:0]   temp_q, temp_d;
  logic          valid_q, valid_d;
  logic [2:0]    err_q, err_d;
  logic [5:0]    step_code;
  logic          in_range;
  state_t        end_state;

  always_comb begin
    step_code = 6'd0;
    case (step_q)
      3'd0:    step_code = 6'd1;
      3'd1:    step_code = 6'd3;
      3'd2:    step_code = 6'd6;
      3'd3:    step_code = 6'd1;
      3'd4:    step_code = 6'd4;
      3'd5:    step_code = 6'd5;
      default: step_code = 6'd0;
    endcase
  end

  // -55 C .. +125 C in 1/16 degree units
  assign in_range  = ($signed(i_data) >= $signed(16'hFC90)) &&
                     ($signed(i_data) <= $signed(16'h07D0));
  assign end_state = i_auto ? S_PERIOD : S_IDLE;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      step_q    <= 3'd0;
      cnt_q     <= '0;
      command_q <= 6'd0;
      temp_q    <= 16'd0;
      valid_q   <= 1'b0;
      err_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      command_q <= command_d;
      temp_q    <= temp_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    command_d = command_q;
    temp_d    = temp_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_start || i_auto) begin
          err_d   = 3'd0;
          step_d  = 3'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!i_busy) begin
          command_d = step_code;
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_irq) begin
          state_d = S_CHECK;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 3'd2;
          cnt_d   = '0;
          state_d = end_state;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        // Presence is only meaningful after the two reset/detect steps
        if ((step_q == 3'd0 || step_q == 3'd3) && !i_detect) begin
          err_d   = 3'd1;
          cnt_d   = '0;
          state_d = end_state;
        end else if (step_q == 3'd5) begin
          state_d = S_PUBLISH;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_PUBLISH: begin
        if (in_range) begin
          temp_d  = i_data;
          valid_d = 1'b1;
        end else begin
          err_d = 3'd3;
        end
        cnt_d   = '0;
        state_d = end_state;
      end
      S_PERIOD: begin
        if (i_start || (i_auto && cnt_q == PERIOD_LAST)) begin
          err_d   = 3'd0;
          step_d  = 3'd0;
          state_d = S_ISSUE;
        end else if (!i_auto) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_enable  = (state_q == S_ISSUE) && !i_busy;
    o_command = o_enable ? step_code : command_q;
    o_busy    = (state_q != S_IDLE) && (state_q != S_PERIOD);
  end

  assign o_temp      = temp_q;
  assign o_temp_int  = temp_q[11:4];
  assign o_temp_frac = temp_q[3:0];
  assign o_valid     = valid_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_ds18b20_sequencer.sv
// tb/tb_ds18b20_sequencer.sv - self-checking bench for ds18b20_sequencer
module tb_ds18b20_sequencer;
  localparam int PER = 50;
  localparam int TO  = 100;

  logic        clk, rst, start, auto_m, en, busy_i, irq, det_i, valid, busy_o;
  logic [5:0]  cmd;
  logic [15:0] data_i, temp;
  logic [7:0]  ti;
  logic [3:0]  tf;
  logic [2:0]  err;

  ds18b20_sequencer #(.P_PERIOD(PER), .P_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_auto(auto_m),
    .o_command(cmd), .o_enable(en), .i_busy(busy_i), .i_irq(irq),
    .i_detect(det_i), .i_data(data_i), .o_temp(temp), .o_temp_int(ti),
    .o_temp_frac(tf), .o_valid(valid), .o_busy(busy_o), .o_err(err)
  );

  typedef struct {
    logic [15:0] t;
    logic [7:0]  ti;
    logic [3:0]  tf;
  } temp_t;

  typedef struct {
    logic [15:0] data;
    logic        det;
    logic [5:0]  noirq;
    logic [2:0]  err;
    int          nvalid;
    logic [15:0] temp;
    logic [7:0]  ti;
    logic [3:0]  tf;
    int          ncmd;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_en = 0;
  int n_valid = 0;
  int poll_edge = -1;
  int fetch_irq_edge = -1;
  logic [5:0]  exp_cmd[$];
  temp_t       exp_temp[$];
  logic [15:0] m_data;
  logic        m_det;
  logic [5:0]  m_noirq;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // Controller model plus scoreboard: outputs sampled at negedge, inputs driven 1ns after posedge
  initial begin : model
    int pending;
    logic [5:0] cur, s_cmd, e;
    logic s_en, s_valid;
    temp_t et;
    pending = 0; cur = 0;
    irq = 0; busy_i = 0; det_i = 0; data_i = 0;
    forever begin
      @(negedge clk);
      s_en = en; s_cmd = cmd; s_valid = valid;
      if (s_en) begin
        n_en++;
        if (exp_cmd.size() == 0) fail_now("unexpected_enable");
        else begin
          e = exp_cmd.pop_front();
          chk("command", s_cmd, e);
        end
        if (s_cmd == 6'd6) poll_edge = cyc + 1;
      end
      if (s_valid) begin
        n_valid++;
        if (exp_temp.size() == 0) fail_now("unexpected_valid");
        else begin
          et = exp_temp.pop_front();
          chk("temp", temp, et.t);
          chk("temp_int", ti, et.ti);
          chk("temp_frac", tf, et.tf);
          chk("valid_latency", cyc - fetch_irq_edge, 2);
        end
      end
      @(posedge clk);
      #1;
      irq = 0;
      if (rst) pending = 0;
      else begin
        if (s_en && s_cmd != m_noirq) begin
          pending = 10;
          cur = s_cmd;
        end
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            irq = 1;
            det_i = m_det;
            data_i = m_data;
            if (cur == 6'd5) fetch_irq_edge = cyc + 1;
          end
        end
      end
      busy_i = (pending > 0);
    end
  end

  task automatic wait_busy(input logic lvl, input string name, output int at);
    at = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (busy_o === lvl) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) fail_now(name);
  endtask

  initial begin : main
    vec_t vecs[9];
    logic [5:0] seq[6];
    int en0, v0, err_edge, f, r, t0;
    logic done;
    seq = '{6'd1, 6'd3, 6'd6, 6'd1, 6'd4, 6'd5};
    vecs[0] = '{16'h0191, 1'b1, 6'd0, 3'd0, 1, 16'h0191, 8'd25, 4'd1,  6};
    vecs[1] = '{16'hFF5E, 1'b1, 6'd0, 3'd0, 1, 16'hFF5E, 8'hF5, 4'd14, 6};
    vecs[2] = '{16'h0191, 1'b0, 6'd0, 3'd1, 0, 16'hFF5E, 8'hF5, 4'd14, 1};
    vecs[3] = '{16'h0191, 1'b1, 6'd6, 3'd2, 0, 16'hFF5E, 8'hF5, 4'd14, 3};
    vecs[4] = '{16'h0800, 1'b1, 6'd0, 3'd3, 0, 16'hFF5E, 8'hF5, 4'd14, 6};
    vecs[5] = '{16'hFC90, 1'b1, 6'd0, 3'd0, 1, 16'hFC90, 8'hC9, 4'd0,  6};
    vecs[6] = '{16'h07D1, 1'b1, 6'd0, 3'd3, 0, 16'hFC90, 8'hC9, 4'd0,  6};
    vecs[7] = '{16'hFC8F, 1'b1, 6'd0, 3'd3, 0, 16'hFC90, 8'hC9, 4'd0,  6};
    vecs[8] = '{16'h07D0, 1'b1, 6'd0, 3'd0, 1, 16'h07D0, 8'h7D, 4'd0,  6};

    rst = 1; start = 0; auto_m = 0;
    m_data = 0; m_det = 1; m_noirq = 0;
    repeat (3) @(negedge clk);
    chk("rst_command", cmd, 0);
    chk("rst_enable", en, 0);
    chk("rst_temp", temp, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 9; i++) begin
      m_data = vecs[i].data;
      m_det = vecs[i].det;
      m_noirq = vecs[i].noirq;
      for (int k = 0; k < vecs[i].ncmd; k++) exp_cmd.push_back(seq[k]);
      if (vecs[i].nvalid != 0) exp_temp.push_back('{vecs[i].temp, vecs[i].ti, vecs[i].tf});
      en0 = n_en; v0 = n_valid; poll_edge = -1; err_edge = -1;
      @(posedge clk);
      #1 start = 1;
      @(posedge clk);
      #1 start = 0;
      @(negedge clk);
      chk("start_busy", busy_o, 1);
      chk("start_enable", en, 1);
      done = 0;
      for (int k = 0; k < 3000 && !done; k++) begin
        @(negedge clk);
        if (err == 3'd2 && err_edge < 0) err_edge = cyc;
        if (!busy_o) done = 1;
      end
      if (!done) fail_now("measurement_end");
      repeat (2) @(negedge clk);
      chk("err", err, vecs[i].err);
      chk("temp_held", temp, vecs[i].temp);
      chk("temp_int_held", ti, vecs[i].ti);
      chk("temp_frac_held", tf, vecs[i].tf);
      chk("enable_count", n_en - en0, vecs[i].ncmd);
      chk("valid_count", n_valid - v0, vecs[i].nvalid);
      chk("cmds_left", exp_cmd.size(), 0);
      if (vecs[i].noirq != 0) chk("timeout_latency", err_edge - poll_edge, TO);
      exp_cmd.delete();
      exp_temp.delete();
      @(posedge clk);
      #1;
    end

    // Periodic mode, then asynchronous reset during the READ of the second measurement
    m_data = 16'h0191; m_det = 1; m_noirq = 0;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 6; k++) exp_cmd.push_back(seq[k]);
      exp_temp.push_back('{16'h0191, 8'd25, 4'd1});
    end
    auto_m = 1;
    wait_busy(1'b1, "auto_first_start", t0);
    wait_busy(1'b0, "auto_first_end", f);
    wait_busy(1'b1, "auto_second_start", r);
    chk("period_gap", r - f, PER);
    chk("auto_err", err, 0);
    done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (en && cmd == 6'd4) done = 1;
    end
    if (!done) fail_now("read_strobe");
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_temp", temp, 0);
    chk("arst_int", ti, 0);
    chk("arst_frac", tf, 0);
    chk("arst_command", cmd, 0);
    chk("arst_enable", en, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_valid", valid, 0);
    chk("arst_err", err, 0);
    chk("arst_cmds_left", exp_cmd.size(), 1);
    @(posedge clk);
    #1 auto_m = 0;
    exp_cmd.delete();
    exp_temp.delete();
    @(posedge clk);
    #1 rst = 0;
    en0 = n_en; v0 = n_valid;
    repeat (60) @(negedge clk);
    chk("post_rst_enables", n_en - en0, 0);
    chk("post_rst_valids", n_valid - v0, 0);
    chk("post_rst_busy", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
